// File: rtl/codec_ctrl_pkg.sv
// Shared types and helpers for the codec control slice: arbiter states and I2C frame packing.
package codec_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_GAP,
    S_RESP
  } arb_state_e;

  localparam logic [7:0] DEV_ADDR_WM8731 = 8'h34;
  localparam int         REG_W           = 7;
  localparam int         DAT_W           = 9;

  // Frame byte order on the wire: device byte, then the 7-bit register, then the 9-bit data.
  function automatic logic [23:0] pack_frame(input logic [7:0]       dev,
                                             input logic [REG_W-1:0] reg_addr,
                                             input logic [DAT_W-1:0] data);
    return {dev, reg_addr, data};
  endfunction

endpackage

// File: rtl/codec_i2c_arbiter_if.sv
// Request/engine/response bundle of the codec I2C arbiter; slave = arbiter side, master = clients and engine.
interface codec_i2c_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]    i_req_valid;
  logic [16*N_REQ-1:0] i_req_data;
  logic [N_REQ-1:0]    o_req_ready;
  logic                o_eng_start;
  logic [23:0]         o_eng_frame;
  logic                i_eng_done;
  logic                i_eng_nack;
  logic                o_rsp_valid;
  logic [ID_W-1:0]     o_rsp_id;
  logic                o_rsp_err;
  logic                o_busy;

  modport slave (
    input  i_req_valid, i_req_data, i_eng_done, i_eng_nack,
    output o_req_ready, o_eng_start, o_eng_frame, o_rsp_valid, o_rsp_id, o_rsp_err, o_busy
  );

  modport master (
    output i_req_valid, i_req_data, i_eng_done, i_eng_nack,
    input  o_req_ready, o_eng_start, o_eng_frame, o_rsp_valid, o_rsp_id, o_rsp_err, o_busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: the first set request at or after ptr wins.
// With CODEC_ARB_FIXED_PRIO_EN defined the search always starts at 0 (plain priority encoder).
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  input  logic                 en,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx
);
  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] cand;
  logic             found;

`ifdef CODEC_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign base       = '0;
  assign unused_ptr = ^ptr;
`else
  assign base = ptr;
`endif

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDX_W'((int'(base) + i) % N);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/codec_i2c_arbiter.sv
// Shares one I2C write engine among N_REQ codec clients with round-robin grant, NACK retry and tagged response.
// Define CODEC_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module codec_i2c_arbiter
  import codec_ctrl_pkg::*;
#(
  parameter int         N_REQ      = 4,
  parameter logic [7:0] DEV_ADDR   = DEV_ADDR_WM8731,
  parameter int         MAX_RETRY  = 2,
  parameter int         GAP_CYCLES = 16
) (
  input logic                i_clk,
  input logic                i_rst_n,
  codec_i2c_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  arb_state_e       state_q, state_d;
  logic [2:0]       retry_cnt_q, retry_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [23:0]      frame_q, frame_d;
  logic [IDX_W-1:0] id_q, id_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0] arb_ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic [N_REQ-1:0] grant;
  logic             arb_en;
  logic [15:0]      req_word [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_word
    assign req_word[k] = bus.i_req_data[16*k +: 16];
  end

  // Ready is gated by reset so it reads zero while i_rst_n is low even with requests pending.
  assign arb_en = (state_q == S_IDLE) && i_rst_n;

  rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
    .req   (bus.i_req_valid),
    .ptr   (arb_ptr),
    .en    (arb_en),
    .grant (grant),
    .idx   (gnt_idx)
  );

`ifdef CODEC_ARB_FIXED_PRIO_EN
  assign arb_ptr = '0;
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (|grant) begin
      rr_ptr_d = (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rr_ptr_q <= '0;
    else          rr_ptr_q <= rr_ptr_d;
  end

  assign arb_ptr = rr_ptr_q;
`endif

  always_comb begin
    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    frame_d     = frame_q;
    id_d        = id_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (|grant) begin
          frame_d     = pack_frame(DEV_ADDR, req_word[gnt_idx][15:9], req_word[gnt_idx][8:0]);
          id_d        = gnt_idx;
          retry_cnt_d = '0;
          err_d       = 1'b0;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.i_eng_done) begin
          if (!bus.i_eng_nack) begin
            err_d   = 1'b0;
            state_d = S_RESP;
          end else if (retry_cnt_q < 3'(MAX_RETRY)) begin
            retry_cnt_d = retry_cnt_q + 3'd1;
            gap_cnt_d   = '0;
            state_d     = S_GAP;
          end else begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      // The gap holds for exactly GAP_CYCLES cycles before the same frame is re-issued.
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) state_d = S_ISSUE;
        else                                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      retry_cnt_q <= '0;
      gap_cnt_q   <= '0;
      frame_q     <= '0;
      id_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      retry_cnt_q <= retry_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_q     <= frame_d;
      id_q        <= id_d;
      err_q       <= err_d;
    end
  end

  assign bus.o_req_ready = grant;
  assign bus.o_eng_start = (state_q == S_ISSUE);
  assign bus.o_eng_frame = frame_q;
  assign bus.o_rsp_valid = (state_q == S_RESP);
  assign bus.o_rsp_id    = id_q;
  assign bus.o_rsp_err   = err_q;
  assign bus.o_busy      = (state_q != S_IDLE);

endmodule
